// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants, width helper and normaliser result layout.
// Pure declarations: no latency and no backpressure of its own.
package fp_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int TAG_W_DEF  = 4;

  // Width needed to hold a leading-zero count of 0..mant_w inclusive.
  function automatic int cnt_w(input int mant_w);
    return $clog2(mant_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(MANT_W_DEF);

  typedef struct packed {
    logic [MANT_W_DEF-1:0] mant;
    logic [EXP_W_DEF-1:0]  exp;
    logic [CNT_W_DEF-1:0]  lz;
    logic                  zero;
    logic                  denorm;
    logic [TAG_W_DEF-1:0]  tag;
  } norm_res_t;

endpackage

// File: rtl/lzc_param.sv
// Width-generic leading-zero counter; combinational, zero latency.
// No backpressure: output follows data in the same cycle.
module lzc_param
  import fp_pkg::*;
#(
  parameter int  MANT_W = MANT_W_DEF,
  localparam int CNT_W  = cnt_w(MANT_W)
) (
  input  logic [MANT_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              all_zero
);

  logic found;

  // Priority search from the MSB; the first set bit fixes the count.
  always_comb begin
    found    = 1'b0;
    count    = CNT_W'(MANT_W);
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        found = 1'b1;
        count = CNT_W'(MANT_W - 1 - i);
      end
    end
    all_zero = !found;
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa normaliser (lzc, then clamped shift); 2-cycle latency, 1 beat/cycle.
// Backpressure: out_ready propagates combinationally to in_ready, no skid buffer.
module fp_norm_pipe
  import fp_pkg::*;
#(
  parameter int  MANT_W = MANT_W_DEF,
  parameter int  EXP_W  = EXP_W_DEF,
  parameter int  TAG_W  = TAG_W_DEF,
  localparam int CNT_W  = cnt_w(MANT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_lz,
  output logic              out_zero,
  output logic              out_denorm,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int SH_W = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [CNT_W-1:0]  lz;
    logic              zero;
    logic              denorm;
    logic [TAG_W-1:0]  tag;
  } res_t;

  logic              s1_valid, s2_valid, s1_adv, s2_adv;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic [TAG_W-1:0]  s1_tag;
  logic [CNT_W-1:0]  s1_lz, lz_cnt;
  logic              s1_zero, lz_zero;
  logic [SH_W-1:0]   lz_ext, exp_ext, shift;
  res_t              s2_d, s2_q;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  lzc_param #(.MANT_W(MANT_W)) u_lzc (
    .data     (in_mant),
    .count    (lz_cnt),
    .all_zero (lz_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_tag   <= '0;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_tag  <= in_tag;
        s1_lz   <= lz_cnt;
        s1_zero <= lz_zero;
      end
    end
  end

  // Shift is capped by the exponent so it bottoms out at 0 instead of wrapping.
  always_comb begin
    lz_ext      = SH_W'(s1_lz);
    exp_ext     = SH_W'(s1_exp);
    shift       = (lz_ext < exp_ext) ? lz_ext : exp_ext;
    s2_d.mant   = s1_mant << shift;
    s2_d.exp    = EXP_W'(exp_ext - shift);
    s2_d.lz     = s1_lz;
    s2_d.zero   = s1_zero;
    s2_d.denorm = (lz_ext > exp_ext) && !s1_zero;
    s2_d.tag    = s1_tag;
    if (s1_zero) begin
      s2_d.mant   = '0;
      s2_d.exp    = '0;
      s2_d.denorm = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid  = s2_valid;
  assign out_mant   = s2_q.mant;
  assign out_exp    = s2_q.exp;
  assign out_lz     = s2_q.lz;
  assign out_zero   = s2_q.zero;
  assign out_denorm = s2_q.denorm;
  assign out_tag    = s2_q.tag;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Bench for fp_norm_pipe: directed vectors, stall stream, async reset, random traffic.
// A negedge scoreboard compares every valid output against an arithmetic model.
module tb_fp_norm_pipe;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant = '0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic [CNT_W-1:0]  out_lz;
  logic              out_zero;
  logic              out_denorm;
  logic [TAG_W-1:0]  out_tag;

  fp_norm_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_lz     (out_lz),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mant;
    int exp;
    int lz;
    int zero;
    int denorm;
    int tag;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int   got_tags[$];
  exp_t cur;
  bit   rand_done;
  bit   saw_ready_low;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Normalisation by arithmetic: bit length gives lz, shift is min(lz, exp).
  function automatic exp_t model(input int m, input int e, input int t);
    exp_t r;
    int   bl = 0;
    int   v  = m;
    int   sh;
    while (v != 0) begin
      v = v / 2;
      bl++;
    end
    r.lz  = MANT_W - bl;
    r.tag = t;
    if (m == 0) begin
      r.mant = 0; r.exp = 0; r.zero = 1; r.denorm = 0;
    end else begin
      sh       = (r.lz < e) ? r.lz : e;
      r.mant   = int'((longint'(m) * (longint'(1) << sh)) % (longint'(1) << MANT_W));
      r.exp    = e - sh;
      r.zero   = 0;
      r.denorm = (r.lz > e) ? 1 : 0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 64'd1, 64'd0);
        end else begin
          cur = sb[0];
          chk("sb_mant", 64'(out_mant), 64'(cur.mant));
          chk("sb_exp", 64'(out_exp), 64'(cur.exp));
          chk("sb_lz", 64'(out_lz), 64'(cur.lz));
          chk("sb_zero", 64'(out_zero), 64'(cur.zero));
          chk("sb_denorm", 64'(out_denorm), 64'(cur.denorm));
          chk("sb_tag", 64'(out_tag), 64'(cur.tag));
          if (out_ready) begin
            got_tags.push_back(int'(out_tag));
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(int'(in_mant), int'(in_exp), int'(in_tag)));
    end
  end

  // Leaves in_valid high on return so callers can stream back to back.
  task automatic drive_beat(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                            input logic [TAG_W-1:0] t);
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    in_tag   = t;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic directed(input logic [MANT_W-1:0] m, input logic [EXP_W-1:0] e,
                          input logic [TAG_W-1:0] t, input int em, input int ee,
                          input int elz, input int ez, input int ed);
    drive_beat(m, e, t);
    in_valid = 1'b0;
    chk("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("dir_valid", 64'(out_valid), 64'd1);
    chk("dir_mant", 64'(out_mant), 64'(em));
    chk("dir_exp", 64'(out_exp), 64'(ee));
    chk("dir_lz", 64'(out_lz), 64'(elz));
    chk("dir_zero", 64'(out_zero), 64'(ez));
    chk("dir_denorm", 64'(out_denorm), 64'(ed));
    chk("dir_tag", 64'(out_tag), 64'(t));
    wait_drain();
  endtask

  initial begin
    logic [31:0] r;
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mant", 64'(out_mant), 64'd0);
    chk("rst_out_exp", 64'(out_exp), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed(24'h800000, 8'd127, 4'd3, 'h800000, 127, 0, 0, 0);
    directed(24'h000001, 8'd100, 4'd4, 'h800000, 77, 23, 0, 0);
    directed(24'h000100, 8'd5, 4'd5, 'h002000, 0, 15, 0, 1);
    directed(24'h000000, 8'd50, 4'd6, 0, 0, 24, 1, 0);
    directed(24'h400000, 8'd0, 4'd7, 'h400000, 0, 1, 0, 1);

    got_tags.delete();
    saw_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_beat(MANT_W'(32'h1000 << i), 8'd40, TAG_W'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_ready_low = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_in_ready_low", 64'(saw_ready_low), 64'd1);
    chk("stream_count", 64'(got_tags.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("stream_order", (i < got_tags.size()) ? 64'(got_tags[i]) : 64'hdead, 64'(i));

    out_ready = 1'b0;
    drive_beat(24'h00abcd, 8'd60, 4'd10);
    drive_beat(24'h0000ff, 8'd60, 4'd11);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    directed(24'h0f0000, 8'd20, 4'd9, 'hf00000, 16, 4, 0, 0);

    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          r = $urandom;
          m = ($urandom_range(0, 15) == 0) ? '0 : MANT_W'(r >> $urandom_range(0, 31));
          e = ($urandom_range(0, 1) == 0) ? EXP_W'($urandom_range(0, 30))
                                          : EXP_W'($urandom_range(0, 255));
          drive_beat(m, e, TAG_W'(i));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined mantissa normaliser for the floating-point datapath.
- Accepts an unnormalised mantissa, exponent and tag; counts leading zeros; left-shifts the mantissa; decrements the exponent.
- Exponent underflow is clamped, producing a denormal result.
- Two registered stages with valid/ready backpressure; sits after add/sub and MAC accumulation.

Parameters:
- MANT_W, 24, mantissa width in bits (>= 2)
- EXP_W, 8, exponent width in bits (unsigned, biased)
- TAG_W, 4, sideband tag width, passed through unchanged
- CNT_W, $clog2(MANT_W+1), leading-zero count width (derived, localparam)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input this cycle
- in_mant  in  MANT_W  unnormalised mantissa
- in_exp  in  EXP_W  biased exponent
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_mant  out  MANT_W  normalised mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_lz  out  CNT_W  leading-zero count of in_mant (0..MANT_W)
- out_zero  out  1  in_mant was all zeros
- out_denorm  out  1  shift limited by exponent (lz > in_exp, mantissa nonzero)
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync-safe deassert):
  - s1_valid and s2_valid clear.
  - All out_* data outputs and out_valid reset to 0.
  - A beat in flight when rst asserts is discarded; no partial result is emitted.
- Stage 1 (S1):
  - Registers mant, exp, tag, lz = number of leading zeros of in_mant (MSB first), zero = (in_mant == 0).
  - lz is computed as a priority search from the MSB, with no case enumeration hard-wired to 24 bits.
- Stage 2 (S2):
  - shift = min(lz, exp) at CNT_W/EXP_W-extended width.
  - mant_out = mant << shift, truncated to MANT_W.
  - exp_out = exp − shift.
  - denorm = (lz > exp) && !zero.
  - Zero input: mant_out = 0, exp_out = 0, lz = MANT_W, zero = 1, denorm = 0.
- Arithmetic:
  - Unsigned throughout; exp_out never wraps below 0.
  - For normalised input (MSB set), output equals input with lz = 0.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - The ready path is combinational back to in_ready; there is no skid buffer.
  - Transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - out_valid = s2_valid; outputs hold stable while out_valid && !out_ready.
- Latency and throughput:
  - Latency is exactly 2 cycles from the accept edge to out_valid when unstalled.
  - Throughput is 1 beat/cycle with out_ready held high.
- Simultaneous events:
  - S2 drains and S1 fills in the same cycle when out_ready = 1; there are no bubbles.
  - in_valid = 0 with the pipe advancing inserts a bubble (valid bit clears; data may hold).
- Ordering: results leave in acceptance order; tags are never reordered or dropped.

Decomposition:
- Shared package fp_pkg:
  - Default MANT_W/EXP_W constants.
  - A clog2-based CNT_W helper function.
  - Typedef of the normaliser result struct {mant, exp, lz, zero, denorm, tag}.
- Sub-module lzc_param (pure combinational, parametrised MANT_W, outputs count and all_zero). It is instantiated in S1 and reused by other FP blocks.
- Pipeline registers and handshake logic live in fp_norm_pipe.

Test Plan:
- Reset then in_mant = 24'h800000, in_exp = 8'd127, tag 3 -> 2 cycles later out_mant = 24'h800000, out_exp = 127, out_lz = 0, out_tag = 3, flags 0.
- in_mant = 24'h000001, in_exp = 8'd100 -> out_mant = 24'h800000, out_exp = 77, out_lz = 23, denorm = 0.
- in_mant = 24'h000100, in_exp = 8'd5 -> lz = 15, shift = 5, out_mant = 24'h002000, out_exp = 0, denorm = 1.
- in_mant = 0, in_exp = 8'd50 -> out_mant = 0, out_exp = 0, out_lz = 24, zero = 1, denorm = 0.
- Back-to-back stream of 8 beats (tags 0..7), out_ready low for 3 cycles mid-stream:
  - in_ready falls once both stages are full.
  - Outputs stay stable during the stall.
  - All 8 results appear in tag order with no loss or duplication.
- rst asserted with both stages valid -> out_valid drops immediately (async); after release, the first new beat emerges at 2-cycle latency with no stale data.
